decoder38_hold: RTL and testbench

Registered 3-to-8 decoder that consumes the `{flag, out_code}` stream produced by the 8-to-3 priority encoder. It turns each accepted code back into a one-hot vector and a 7-segment digit, then holds the result for a programmable number of cycles so it can drive LEDs and the seven-segment display on the board. Input uses a valid/ready handshake, so upstream stalls while a code is being held. A running count of accepted codes is kept for debug.

---
 rtl/decoder38_hold.sv | 114 +++++++++++
 tb/tb_decoder38_hold.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder38_hold.sv
// Registered 3-to-8 decoder with 7-segment output. Each accepted code is held on
// the outputs for HOLD_CYCLES cycles; upstream is stalled through in_ready meanwhile.
module decoder38_hold #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_onehot,
    output logic [7:0] seg,
    output logic [7:0] accept_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] TMR_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [2:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_onehot_q, out_onehot_d;
    logic [7:0] seg_q, seg_d;
    logic       xfer;

    // Active-low segments, bit0=a .. bit6=g, dp kept dark.
    function automatic logic [7:0] seg_of(input logic [2:0] code);
        logic [7:0] s;
        case (code)
            3'd0:    s = 8'hC0;
            3'd1:    s = 8'hF9;
            3'd2:    s = 8'hA4;
            3'd3:    s = 8'hB0;
            3'd4:    s = 8'h99;
            3'd5:    s = 8'h92;
            3'd6:    s = 8'h82;
            default: s = 8'hF8;
        endcase
        return s;
    endfunction

    // Ready depends only on registered state and en; the last hold cycle accepts.
    assign in_ready = en && (state_q == IDLE || tmr_q == 8'd0);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d = HOLD;
                        tmr_d   = TMR_LOAD;
                        code_d  = in_code;
                    end
                end
                HOLD: begin
                    if (tmr_q != 8'd0) begin
                        tmr_d = tmr_q - 8'd1;
                    end else if (xfer) begin
                        tmr_d  = TMR_LOAD;
                        code_d = in_code;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (xfer) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Outputs are registered copies of what the next state will show.
        out_valid_d  = (state_d == HOLD);
        out_onehot_d = out_valid_d ? (8'd1 << code_d) : 8'h00;
        seg_d        = out_valid_d ? seg_of(code_d) : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tmr_q        <= 8'd0;
            code_q       <= 3'd0;
            cnt_q        <= 8'd0;
            out_valid_q  <= 1'b0;
            out_onehot_q <= 8'h00;
            seg_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            seg_q        <= seg_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign seg        = seg_q;
    assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_decoder38_hold.sv
// Bench for decoder38_hold: one instance with HOLD_CYCLES=4 and one with HOLD_CYCLES=1,
// each with its own expected queue and output monitor.
module tb_decoder38_hold;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // HOLD_CYCLES=4 instance
    logic       rst4, en4, iv4;
    logic [2:0] ic4;
    logic       ir4, ov4;
    logic [7:0] oh4, seg4, cnt4;

    // HOLD_CYCLES=1 instance
    logic       rst1, en1, iv1;
    logic [2:0] ic1;
    logic       ir1, ov1;
    logic [7:0] oh1, seg1, cnt1;

    decoder38_hold #(.HOLD_CYCLES(4)) u4 (
        .clk(clk), .rst(rst4), .en(en4), .in_valid(iv4), .in_code(ic4),
        .in_ready(ir4), .out_valid(ov4), .out_onehot(oh4), .seg(seg4), .accept_cnt(cnt4)
    );

    decoder38_hold #(.HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .in_valid(iv1), .in_code(ic1),
        .in_ready(ir1), .out_valid(ov1), .out_onehot(oh1), .seg(seg1), .accept_cnt(cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic mon4_en = 1'b0;
    logic mon1_en = 1'b0;

    // Expected {onehot, seg}, one entry per cycle of out_valid=1.
    logic [15:0] exp4_q[$];
    logic [15:0] exp1_q[$];

    logic [7:0] seg_tab [8];
    initial begin
        seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
        seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    end

    function automatic logic [15:0] exp_of(input logic [2:0] c);
        logic [7:0] oh;
        oh = 8'd1 << c;
        return {oh, seg_tab[c]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: out_valid must be high exactly while expected entries are pending.
    always @(negedge clk) begin
        if (mon4_en) begin
            check("u4_valid_vs_queue", {31'd0, ov4}, {31'd0, exp4_q.size() != 0});
            if (ov4 && exp4_q.size() != 0) begin
                check("u4_out", {16'd0, oh4, seg4}, {16'd0, exp4_q.pop_front()});
            end else if (!ov4) begin
                check("u4_blank", {16'd0, oh4, seg4}, 32'h0000_00FF);
            end
        end
    end

    always @(negedge clk) begin
        if (mon1_en) begin
            check("u1_valid_vs_queue", {31'd0, ov1}, {31'd0, exp1_q.size() != 0});
            if (ov1 && exp1_q.size() != 0) begin
                check("u1_out", {16'd0, oh1, seg1}, {16'd0, exp1_q.pop_front()});
            end else if (!ov1) begin
                check("u1_blank", {16'd0, oh1, seg1}, 32'h0000_00FF);
            end
        end
    end

    task automatic reset4();
        @(posedge clk); #1;
        rst4 = 1'b1; iv4 = 1'b0; en4 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        exp4_q.delete();
    endtask

    // Offer code c until accepted; push n visible cycles. Returns #1 after the transfer edge.
    task automatic offer4(input logic [2:0] c, input int n, output int waited);
        waited = 0;
        iv4 = 1'b1;
        ic4 = c;
        forever begin
            @(negedge clk);
            if (ir4) break;
            if (waited >= 20) begin
                check("u4_accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) exp4_q.push_back(exp_of(c));
    endtask

    task automatic idle4(input int n);
        iv4 = 1'b0;
        ic4 = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int w;
        rst4 = 1'b1; en4 = 1'b0; iv4 = 1'b0; ic4 = 3'd0;
        rst1 = 1'b1; en1 = 1'b0; iv1 = 1'b0; ic1 = 3'd0;

        // Reset values
        reset4();
        mon4_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, ov4}, 32'd0);
        check("rst_onehot", {24'd0, oh4}, 32'h00);
        check("rst_seg", {24'd0, seg4}, 32'hFF);
        check("rst_cnt", {24'd0, cnt4}, 32'd0);
        check("rst_in_ready", {31'd0, ir4}, 32'd1);
        @(posedge clk); #1;

        // Single code 5 held 4 cycles
        offer4(3'd5, 4, w);
        idle4(6);
        check("single_cnt", {24'd0, cnt4}, 32'd1);

        // Back-to-back codes 0..7
        reset4();
        for (int c = 0; c < 8; c++) begin
            offer4(3'(c), 4, w);
            if (c > 0) check("b2b_ready_spacing", w, 32'd3);
        end
        idle4(6);
        check("b2b_cnt", {24'd0, cnt4}, 32'd8);

        // Enable drop in the second hold cycle
        reset4();
        offer4(3'd3, 2, w);
        iv4 = 1'b0;
        @(posedge clk); #1;
        en4 = 1'b0;
        @(negedge clk);
        check("endrop_ready_low", {31'd0, ir4}, 32'd0);
        @(posedge clk); #1;
        iv4 = 1'b1;
        @(negedge clk);
        check("endrop_idle_ready", {31'd0, ir4}, 32'd0);
        check("endrop_idle_valid", {31'd0, ov4}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("endrop_cnt", {24'd0, cnt4}, 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        en4 = 1'b1;
        idle4(2);

        // Reset in the last hold cycle with a simultaneous offer
        offer4(3'd6, 4, w);
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        iv4 = 1'b1;
        ic4 = 3'd2;
        @(negedge clk);
        check("rstmid_cnt_before", {24'd0, cnt4}, 32'd2);
        @(posedge clk); #1;
        rst4 = 1'b0;
        iv4 = 1'b0;
        @(negedge clk);
        check("rstmid_cnt", {24'd0, cnt4}, 32'd0);
        check("rstmid_valid", {31'd0, ov4}, 32'd0);
        idle4(3);

        // HOLD_CYCLES=1: 257 consecutive transfers
        @(posedge clk); #1;
        rst1 = 1'b1; en1 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        mon1_en = 1'b1;
        iv1 = 1'b1;
        for (int i = 0; i < 257; i++) begin
            ic1 = 3'(i % 8);
            @(negedge clk);
            if (!ir1) check("u1_ready_high", {31'd0, ir1}, 32'd1);
            @(posedge clk); #1;
            if (ir1 || i == 256) exp1_q.push_back(exp_of(3'(i % 8)));
        end
        iv1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("wrap_cnt", {24'd0, cnt1}, 32'd1);
        check("u4_queue_drained", exp4_q.size(), 32'd0);
        check("u1_queue_drained", exp1_q.size(), 32'd0);

        mon4_en = 1'b0;
        mon1_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
